reg_scoreboard: RTL and testbench



---
 rtl/reg_pkg.sv | 6 +
 rtl/reg_sb_cnt.sv | 38 +++
 rtl/reg_scoreboard.sv | 82 ++++++++
 tb/tb_reg_scoreboard.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared register-address types and defaults for the pending-write scoreboard.
package reg_pkg;
  localparam int REG_AW       = 5;
  localparam int NREG_DEFAULT = 32;
  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/reg_sb_cnt.sv
// One per-register in-flight write counter; clear wins over inc/dec, dec at zero is reported not applied.
module reg_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o,
  output logic             full_o,
  output logic             under_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_eff;

  assign nz_o    = (cnt_q != '0);
  assign full_o  = &cnt_q;
  assign under_o = dec_i & ~nz_o;
  assign dec_eff = dec_i & nz_o;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !dec_eff && !full_o)
      cnt_d = cnt_q + 1'b1;
    else if (dec_eff && !inc_i)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: stalls issue on RAW hazards against in-flight writes,
// with a same-cycle writeback bypass for the last outstanding write of a source.
module reg_scoreboard
  import reg_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid_i,
  input  reg_addr_t       issue_rs1_i,
  input  reg_addr_t       issue_rs2_i,
  input  logic            issue_uses_rs2_i,
  input  reg_addr_t       issue_rd_i,
  input  logic            issue_rd_we_i,
  output logic            issue_ready_o,
  output logic            stall_o,
  input  logic            wb_valid_i,
  input  reg_addr_t       wb_rd_i,
  input  logic            flush_i,
  output logic [NREG-1:0] busy_o,
  output logic            err_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_w [NREG];
  logic [NREG-1:0]  nz_w, full_w, under_w, inc_w, dec_w;
  logic             pend_rs1, pend_rs2, hazard, sat, accept;
  logic             err_q, err_d;

  // x0 has no counter and always reads as idle
  assign cnt_w[0]   = '0;
  assign nz_w[0]    = 1'b0;
  assign full_w[0]  = 1'b0;
  assign under_w[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush_i),
      .inc_i   (inc_w[r]),
      .dec_i   (dec_w[r]),
      .cnt_o   (cnt_w[r]),
      .nz_o    (nz_w[r]),
      .full_o  (full_w[r]),
      .under_o (under_w[r])
    );
  end

  // Write-through register file lets a source whose last pending write retires this cycle proceed
  assign pend_rs1 = nz_w[issue_rs1_i] &
                    ~(wb_valid_i && (wb_rd_i == issue_rs1_i) && (cnt_w[issue_rs1_i] == CNT_ONE));
  assign pend_rs2 = nz_w[issue_rs2_i] &
                    ~(wb_valid_i && (wb_rd_i == issue_rs2_i) && (cnt_w[issue_rs2_i] == CNT_ONE));
  assign hazard   = pend_rs1 | (issue_uses_rs2_i & pend_rs2);
  assign sat      = issue_rd_we_i & (issue_rd_i != '0) & full_w[issue_rd_i] & ~dec_w[issue_rd_i];

  assign issue_ready_o = ~hazard & ~sat & ~flush_i;
  assign stall_o       = issue_valid_i & ~issue_ready_o;
  assign accept        = issue_valid_i & issue_ready_o & issue_rd_we_i & (issue_rd_i != '0);

  always_comb begin
    inc_w = '0;
    dec_w = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_w[r] = accept && (issue_rd_i == reg_addr_t'(r));
      dec_w[r] = wb_valid_i && (wb_rd_i == reg_addr_t'(r));
    end
  end

  assign err_d = err_q | (|under_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign busy_o = nz_w;
  assign err_o  = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, corner-case sequences and random traffic vs. a model.
module tb_reg_scoreboard;
  import reg_pkg::*;
  localparam int NR = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            iv, uses, we, wbv, fl;
  reg_addr_t       rs1, rs2, rd, wbrd;
  logic            ready, stall, err;
  logic [NR-1:0]   busy;

  int cnt_m [NR];
  bit err_m;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(NR), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(iv), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_uses_rs2_i(uses), .issue_rd_i(rd), .issue_rd_we_i(we),
    .issue_ready_o(ready), .stall_o(stall),
    .wb_valid_i(wbv), .wb_rd_i(wbrd), .flush_i(fl),
    .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input int s1, input int s2, input logic u,
                        input int d, input logic w, input logic wv, input int wd, input logic f);
    iv = v; rs1 = reg_addr_t'(s1); rs2 = reg_addr_t'(s2); uses = u;
    rd = reg_addr_t'(d); we = w; wbv = wv; wbrd = reg_addr_t'(wd); fl = f;
  endtask

  // Reference model: a register's source is pending unless its only outstanding write retires now
  function automatic bit m_pend(int s);
    return s != 0 && cnt_m[s] != 0 && !(wbv && int'(wbrd) == s && cnt_m[s] == 1);
  endfunction

  function automatic bit m_ready();
    bit haz, sat;
    haz = m_pend(int'(rs1)) || (uses && m_pend(int'(rs2)));
    sat = we && rd != 0 && cnt_m[rd] == 3 && !(wbv && wbrd == rd);
    return !haz && !sat && !fl;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < NR; i++) b[i] = (cnt_m[i] != 0);
    return b;
  endfunction

  task automatic m_advance();
    bit acc, dec;
    acc = iv && m_ready() && we && rd != 0;
    dec = wbv && wbrd != 0 && cnt_m[wbrd] != 0;
    if (wbv && wbrd != 0 && cnt_m[wbrd] == 0) err_m = 1'b1;
    if (fl) begin
      for (int i = 0; i < NR; i++) cnt_m[i] = 0;
    end else begin
      if (acc) cnt_m[rd] = cnt_m[rd] + 1;
      if (dec) cnt_m[wbrd] = cnt_m[wbrd] - 1;
    end
  endtask

  task automatic step(input string tag);
    #2;
    chk({tag, "_ready"}, ready, m_ready());
    chk({tag, "_stall"}, stall, iv & ~m_ready());
    chk({tag, "_busy"}, busy, m_busy());
    chk({tag, "_err"}, err, err_m);
    m_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic m_reset();
    for (int i = 0; i < NR; i++) cnt_m[i] = 0;
    err_m = 1'b0;
  endtask

  typedef struct {
    logic v; int s1; int s2; logic u; int d; logic w; logic wv; int wd; logic f;
    logic rdy; logic stl; logic [31:0] bsy; logic e;
  } vec_t;
  vec_t tbl [11];

  initial begin
    // rd=3 issue, then rd=5 followed by a dependent held 4 cycles and released by wb x5
    tbl[0]  = '{1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b0};
    tbl[2]  = '{1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b0};
    tbl[3]  = '{1'b1, 5, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0028, 1'b0};
    tbl[4]  = '{1'b1, 5, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0028, 1'b0};
    tbl[5]  = '{1'b1, 5, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0028, 1'b0};
    tbl[6]  = '{1'b1, 5, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0028, 1'b0};
    tbl[7]  = '{1'b1, 5, 0, 1'b0, 0, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0, 32'h0000_0028, 1'b0};
    tbl[8]  = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b0};
    tbl[9]  = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b0};
    tbl[10] = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0};

    m_reset();
    rst = 1'b1;
    set_in(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("reset_busy", busy, 32'h0);
    chk("reset_err", err, 1'b0);
    chk("reset_ready", ready, 1'b1);
    chk("reset_stall", stall, 1'b0);
    step("reset_idle");

    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].u, tbl[i].d, tbl[i].w, tbl[i].wv, tbl[i].wd, tbl[i].f);
      #2;
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].stl);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e);
      m_advance();
      @(posedge clk);
      @(negedge clk);
    end

    // Saturation on x7, then the fourth issue slips through with a same-cycle retire
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 0, 0, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0);
      step("sat_fill");
    end
    set_in(1'b1, 0, 0, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0);
    #1;
    chk("sat_stall", stall, 1'b1);
    step("sat_hold");
    set_in(1'b1, 0, 0, 1'b0, 7, 1'b1, 1'b1, 7, 1'b0);
    #1;
    chk("sat_bypass_ready", ready, 1'b1);
    step("sat_bypass");
    set_in(1'b1, 0, 0, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0);
    #1;
    chk("sat_still_full", stall, 1'b1);
    step("sat_still_full");
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 7, 1'b0);
      step("sat_drain");
    end

    // x0 is never tracked; writeback of an idle register is a sticky error
    set_in(1'b1, 0, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
    #1;
    chk("x0_ready", ready, 1'b1);
    step("x0_issue");
    set_in(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
    step("x0_wb");
    chk("x0_busy0", busy[0], 1'b0);
    chk("x0_no_err", err, 1'b0);
    set_in(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 9, 1'b0);
    step("err_wb9");
    set_in(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("err_set", err, 1'b1);
    step("err_hold1");
    step("err_hold2");
    chk("err_sticky", err, 1'b1);

    // Flush beats a same-cycle accept-eligible issue
    set_in(1'b1, 0, 0, 1'b0, 4, 1'b1, 1'b0, 0, 1'b0);
    step("fl_x4");
    set_in(1'b1, 0, 0, 1'b0, 6, 1'b1, 1'b0, 0, 1'b0);
    step("fl_x6");
    set_in(1'b1, 0, 0, 1'b0, 4, 1'b1, 1'b0, 0, 1'b1);
    #1;
    chk("fl_ready", ready, 1'b0);
    step("fl_flush");
    set_in(1'b1, 4, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("fl_busy_clear", busy, 32'h0);
    chk("fl_dep_ready", ready, 1'b1);
    step("fl_dep");

    // Asynchronous reset in the middle of the low phase
    set_in(1'b1, 0, 0, 1'b0, 8, 1'b1, 1'b0, 0, 1'b0);
    step("ar_x8");
    set_in(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("ar_busy_before", busy[8], 1'b1);
    rst = 1'b1;
    #1;
    chk("ar_busy_async", busy, 32'h0);
    chk("ar_err_async", err, 1'b0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic on a narrow register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom % 2), $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom % 2),
             $urandom_range(0, 7), 1'(($urandom % 4) != 0), 1'(($urandom % 3) == 0),
             $urandom_range(0, 7), 1'(($urandom % 20) == 0));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
